y86_seq_controller: RTL and testbench
=====================================

// Module: y86_seq_controller
// PURPOSE
//  Multi-cycle sequencer for the sequential Y86-64 core. Owns the PC, the Status register and the
//  condition-code register. Issues one-hot stage enables Fetch->Decode->Execute->Memory->Writeback->PC
//  update. Stops the core on halt or error. Supports single-step debug and a data-memory ready handshake.
// PARAMETERS
//  PC_WIDTH     64   width of PC / NewPC
//  IMEM_LIMIT   256  first invalid instruction address; PC >= IMEM_LIMIT is an address error
//  RESET_PC     0    PC value loaded on reset
//  CNT_WIDTH    32   width of cycle and instruction counters
//  MEM_TIMEOUT  15   max cycles spent waiting on Mem_Ready before an address error
// PORTS
//  Clk                 in   1         clock, rising edge
//  Reset_n             in   1         asynchronous, active-low reset
//  Start               in   1         level; begins execution from IDLE
//  Step_Mode           in   1         1 = pause after each instruction
//  Step                in   1         1-cycle pulse; releases one instruction while paused
//  icode               in   4         decoded icode from Fetch
//  HLT, INS, ADR       in   1 each    Fetch status flags
//  DataMemError        in   1         data memory out-of-bounds
//  Mem_Ready           in   1         data memory access complete
//  NewPC               in   PC_WIDTH  next PC from PC_Update
//  ConditionCodes_Out  in   3         ZF,SF,OF from Execute
//  PC                  out  PC_WIDTH  program counter
//  Fetch_En, Decode_En, Execute_En, Memory_En, Writeback_En   out 1 each   one-hot stage strobes
//  ConditionCodes      out  3         registered CC (ZF,SF,OF)
//  Status              out  4         1=AOK 2=ADR 3=INS 4=HLT
//  Running             out  1         high in any stage state
//  Halted              out  1         high in STOPPED
//  Cycle_Count, Instr_Count   out CNT_WIDTH   performance counters
// BEHAVIOUR
//  - Reset (async): state=IDLE, PC=RESET_PC, ConditionCodes=3'b000, Status=1, all enables 0,
//    Running=0, Halted=0, counters=0. Reset applied mid-instruction aborts it with no register write.
//  - States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, PAUSE, STOPPED.
//    Each stage state lasts 1 cycle, except MEMORY. The matching *_En is high for exactly that state.
//  - IDLE -> FETCH when Start=1. Start is ignored in every other state.
//  - FETCH: evaluate flags in priority order HLT > INS > (ADR or PC >= IMEM_LIMIT).
//    HLT gives Status=4, INS gives Status=3, address error gives Status=2; each goes to STOPPED.
//    Otherwise -> DECODE.
//  - DECODE -> EXECUTE -> MEMORY.
//  - EXECUTE: when icode==4'h6 (OPq), ConditionCodes <= ConditionCodes_Out at the end of the cycle.
//    No other icode changes CC.
//  - MEMORY: hold Memory_En until Mem_Ready=1, then -> WRITEBACK. DataMemError=1 in any MEMORY cycle
//    sets Status=2 and goes to STOPPED; Writeback_En is never asserted for that instruction.
//    If Mem_Ready stays 0 for MEMORY_TIMEOUT consecutive cycles, treat it the same as DataMemError.
//    If Mem_Ready and DataMemError are high in the same cycle, the error wins.
//  - WRITEBACK -> PCUPD.
//  - PCUPD: PC <= NewPC; Instr_Count++. Then -> PAUSE if Step_Mode=1, else -> FETCH.
//  - PAUSE: all enables 0. A Step pulse, or Step_Mode deasserting, -> FETCH.
//  - STOPPED: terminal until Reset_n. PC holds the PC of the faulting/halting instruction.
//    Status is frozen.
//  - Cycle_Count increments every cycle while Running. Both counters saturate at all-ones (no wrap).
//  - PC update is a plain load; no arithmetic wrap handling. Overflow of NewPC is caught by the
//    next FETCH range check.
// STRUCTURE
//  - Shared package y86_ctrl_pkg:
//      STAT_AOK=1, STAT_ADR=2, STAT_INS=3, STAT_HLT=4;
//      ICODE_* constants (at least ICODE_OPQ=4'h6, ICODE_HALT=4'h0);
//      state encoding typedef/localparams.
//  - One sub-module: y86_mem_wait_timer. Counts Mem_Ready-low cycles while Memory_En is high and
//    flags the timeout; cleared on leaving MEMORY.
//  - Everything else is a single FSM plus registers in this module.
// TESTING
//  1. Reset with Start=1; program irmovq $5,%rax ; halt.
//     -> enables sequence F,D,E,M,W, PC 0->10, Instr_Count=1; then HLT in FETCH -> Status=4,
//        Halted=1, PC=10.
//  2. Invalid icode 4'hF at PC=0 -> Status=3 after the FETCH cycle; Decode_En never asserted;
//     PC stays 0.
//  3. addq with ConditionCodes_Out=3'b100 during EXECUTE -> ConditionCodes=3'b100.
//     A following irmovq with ConditionCodes_Out=3'b010 -> ConditionCodes stays 3'b100.
//  4. Mem_Ready held 0 for 3 cycles, then 1 -> Memory_En high for 4 cycles and exactly one
//     Writeback_En. Mem_Ready held 0 for MEM_TIMEOUT cycles -> Status=2, no Writeback_En.
//  5. Step_Mode=1 -> controller parks in PAUSE after each PCUPD. One Step pulse -> exactly one more
//     instruction (Instr_Count +1).
//  6. Reset_n deasserted during MEMORY -> outputs return to reset values in the same cycle
//     (asynchronous); no Writeback_En.
//     NewPC=256 -> next FETCH gives Status=2.

Source files
------------

// File: rtl/y86_ctrl_pkg.sv
// Shared definitions for the sequential Y86-64 controller: status codes,
// instruction codes, the sequencer state encoding and the fetch-status
// priority helper.
package y86_ctrl_pkg;

    // Architectural status codes
    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_ADR = 4'd2;
    localparam logic [3:0] STAT_INS = 4'd3;
    localparam logic [3:0] STAT_HLT = 4'd4;

    // Instruction codes
    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXECUTE   = 4'd3,
        ST_MEMORY    = 4'd4,
        ST_WRITEBACK = 4'd5,
        ST_PCUPD     = 4'd6,
        ST_PAUSE     = 4'd7,
        ST_STOPPED   = 4'd8
    } ctrl_state_e;

    // Fetch faults in priority order: halt beats invalid instruction beats address error.
    function automatic logic [3:0] fetch_status(input logic hlt, input logic ins, input logic adr_err);
        logic [3:0] stat;
        if (hlt) begin
            stat = STAT_HLT;
        end else if (ins) begin
            stat = STAT_INS;
        end else if (adr_err) begin
            stat = STAT_ADR;
        end else begin
            stat = STAT_AOK;
        end
        return stat;
    endfunction

endpackage

// File: rtl/y86_seq_controller_if.sv
// Bus between the Y86-64 sequencer and the rest of the core.
//   inputs to controller : Start, Step_Mode, Step, icode, HLT/INS/ADR, DataMemError,
//                          Mem_Ready, NewPC, ConditionCodes_Out
//   outputs of controller: PC, stage enables, ConditionCodes, Status, Running, Halted,
//                          Cycle_Count, Instr_Count
// master = core/environment side, slave = controller side.
interface y86_seq_controller_if #(
    parameter int PC_WIDTH  = 64,
    parameter int CNT_WIDTH = 32
);
    logic                 Start;
    logic                 Step_Mode;
    logic                 Step;
    logic [3:0]           icode;
    logic                 HLT;
    logic                 INS;
    logic                 ADR;
    logic                 DataMemError;
    logic                 Mem_Ready;
    logic [PC_WIDTH-1:0]  NewPC;
    logic [2:0]           ConditionCodes_Out;

    logic [PC_WIDTH-1:0]  PC;
    logic                 Fetch_En;
    logic                 Decode_En;
    logic                 Execute_En;
    logic                 Memory_En;
    logic                 Writeback_En;
    logic [2:0]           ConditionCodes;
    logic [3:0]           Status;
    logic                 Running;
    logic                 Halted;
    logic [CNT_WIDTH-1:0] Cycle_Count;
    logic [CNT_WIDTH-1:0] Instr_Count;

    modport master (
        output Start, Step_Mode, Step, icode, HLT, INS, ADR, DataMemError, Mem_Ready,
               NewPC, ConditionCodes_Out,
        input  PC, Fetch_En, Decode_En, Execute_En, Memory_En, Writeback_En,
               ConditionCodes, Status, Running, Halted, Cycle_Count, Instr_Count
    );

    modport slave (
        input  Start, Step_Mode, Step, icode, HLT, INS, ADR, DataMemError, Mem_Ready,
               NewPC, ConditionCodes_Out,
        output PC, Fetch_En, Decode_En, Execute_En, Memory_En, Writeback_En,
               ConditionCodes, Status, Running, Halted, Cycle_Count, Instr_Count
    );
endinterface

// File: rtl/y86_mem_wait_timer.sv
// Counts consecutive Mem_Ready-low cycles while the MEMORY stage is active and
// flags a timeout in the MEM_TIMEOUT-th such cycle. Cleared whenever MEMORY is left.
// Ports: Clk, Reset_n (async active-low), Mem_En (MEMORY stage active),
//        Mem_Ready (access complete), Timeout (combinational flag for this cycle).
module y86_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Mem_En,
    input  logic Mem_Ready,
    output logic Timeout
);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] wait_cnt_r;

    // Wait counter: holds the number of low cycles already completed in this MEMORY visit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (!Mem_En || Mem_Ready) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (wait_cnt_r != LAST) begin
            wait_cnt_r <= wait_cnt_r + CW'(1'b1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign Timeout = Mem_En && !Mem_Ready && (wait_cnt_r == LAST);
endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the sequential Y86-64 core. Owns PC, Status and the
// condition codes; walks FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK->PCUPD with
// one-hot stage enables, stops on halt/error, supports single-step via PAUSE.
// Ports: Clk, Reset_n (async active-low), bus (y86_seq_controller_if.slave) carrying
//        all control inputs and architectural/performance outputs.
module y86_seq_controller
    import y86_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  IMEM_LIMIT  = 256,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  CNT_WIDTH   = 32,
    parameter int                  MEM_TIMEOUT = 15
) (
    input  logic                Clk,
    input  logic                Reset_n,
    y86_seq_controller_if.slave bus
);
    localparam logic [PC_WIDTH-1:0]  IMEM_LIMIT_PC = PC_WIDTH'(IMEM_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX       = {CNT_WIDTH{1'b1}};

    ctrl_state_e          state_r;
    ctrl_state_e          state_next_s;
    logic [PC_WIDTH-1:0]  pc_r;
    logic [2:0]           cc_r;
    logic [3:0]           status_r;
    logic [CNT_WIDTH-1:0] cycle_cnt_r;
    logic [CNT_WIDTH-1:0] instr_cnt_r;
    logic [3:0]           fetch_stat_s;
    logic                 mem_timeout_s;
    logic                 mem_fault_s;
    logic                 fetch_en_s;
    logic                 decode_en_s;
    logic                 execute_en_s;
    logic                 memory_en_s;
    logic                 writeback_en_s;
    logic                 running_s;
    logic                 halted_s;

    // Out-of-range PC is folded into the ADR flag before prioritisation.
    assign fetch_stat_s = fetch_status(bus.HLT, bus.INS, bus.ADR || (pc_r >= IMEM_LIMIT_PC));
    // A data-memory error or a stalled access both end the instruction as ADR.
    assign mem_fault_s  = bus.DataMemError || mem_timeout_s;

    y86_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Mem_En    (memory_en_s),
        .Mem_Ready (bus.Mem_Ready),
        .Timeout   (mem_timeout_s)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:      if (bus.Start) state_next_s = ST_FETCH; else state_next_s = ST_IDLE;
            ST_FETCH:     if (fetch_stat_s != STAT_AOK) state_next_s = ST_STOPPED;
                          else state_next_s = ST_DECODE;
            ST_DECODE:    state_next_s = ST_EXECUTE;
            ST_EXECUTE:   state_next_s = ST_MEMORY;
            // Error outranks a simultaneous Mem_Ready.
            ST_MEMORY:    if (mem_fault_s) state_next_s = ST_STOPPED;
                          else if (bus.Mem_Ready) state_next_s = ST_WRITEBACK;
                          else state_next_s = ST_MEMORY;
            ST_WRITEBACK: state_next_s = ST_PCUPD;
            ST_PCUPD:     if (bus.Step_Mode) state_next_s = ST_PAUSE; else state_next_s = ST_FETCH;
            ST_PAUSE:     if (bus.Step || !bus.Step_Mode) state_next_s = ST_FETCH;
                          else state_next_s = ST_PAUSE;
            ST_STOPPED:   state_next_s = ST_STOPPED;
            default:      state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: stage strobes and run/halt indicators from the state register.
    always_comb begin
        fetch_en_s     = 1'b0;
        decode_en_s    = 1'b0;
        execute_en_s   = 1'b0;
        memory_en_s    = 1'b0;
        writeback_en_s = 1'b0;
        running_s      = 1'b0;
        halted_s       = 1'b0;
        case (state_r)
            ST_FETCH:     begin fetch_en_s     = 1'b1; running_s = 1'b1; end
            ST_DECODE:    begin decode_en_s    = 1'b1; running_s = 1'b1; end
            ST_EXECUTE:   begin execute_en_s   = 1'b1; running_s = 1'b1; end
            ST_MEMORY:    begin memory_en_s    = 1'b1; running_s = 1'b1; end
            ST_WRITEBACK: begin writeback_en_s = 1'b1; running_s = 1'b1; end
            ST_PCUPD:     running_s = 1'b1;
            ST_STOPPED:   halted_s  = 1'b1;
            default:      running_s = 1'b0;
        endcase
    end

    // Architectural registers (PC, CC, Status) and saturating performance counters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_r        <= RESET_PC;
            cc_r        <= 3'b000;
            status_r    <= STAT_AOK;
            cycle_cnt_r <= {CNT_WIDTH{1'b0}};
            instr_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (running_s && (cycle_cnt_r != CNT_MAX)) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_WIDTH'(1'b1);
            end
            case (state_r)
                ST_FETCH: begin
                    if (fetch_stat_s != STAT_AOK) status_r <= fetch_stat_s;
                end
                ST_EXECUTE: begin
                    if (bus.icode == ICODE_OPQ) cc_r <= bus.ConditionCodes_Out;
                end
                ST_MEMORY: begin
                    if (mem_fault_s) status_r <= STAT_ADR;
                end
                ST_PCUPD: begin
                    pc_r <= bus.NewPC;
                    if (instr_cnt_r != CNT_MAX) instr_cnt_r <= instr_cnt_r + CNT_WIDTH'(1'b1);
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign bus.PC             = pc_r;
    assign bus.ConditionCodes = cc_r;
    assign bus.Status         = status_r;
    assign bus.Cycle_Count    = cycle_cnt_r;
    assign bus.Instr_Count    = instr_cnt_r;
    assign bus.Fetch_En       = fetch_en_s;
    assign bus.Decode_En      = decode_en_s;
    assign bus.Execute_En     = execute_en_s;
    assign bus.Memory_En      = memory_en_s;
    assign bus.Writeback_En   = writeback_en_s;
    assign bus.Running        = running_s;
    assign bus.Halted         = halted_s;
endmodule

// File: tb/tb_y86_seq_controller.sv
// Scoreboard bench for y86_seq_controller: directed instruction vectors push the
// expected stage events; a monitor pops one entry per observed strobe/halt event.
module tb_y86_seq_controller;
    import y86_ctrl_pkg::*;

    localparam int PCW   = 64;
    localparam int CW    = 32;
    localparam int MEMTO = 15;

    // strobe vector bit order: {Halted-rise, W, M, E, D, F}
    localparam logic [5:0] S_F    = 6'b000001;
    localparam logic [5:0] S_D    = 6'b000010;
    localparam logic [5:0] S_E    = 6'b000100;
    localparam logic [5:0] S_M    = 6'b001000;
    localparam logic [5:0] S_W    = 6'b010000;
    localparam logic [5:0] S_STOP = 6'b100000;
    localparam logic [159:0] RESET_SNAP =
        160'({64'd0, 3'b000, 4'd1, 5'b00000, 1'b0, 1'b0, 32'd0, 32'd0});

    typedef struct packed {
        logic [5:0]  strobes;
        logic [63:0] pc;
        logic [2:0]  cc;
        logic [3:0]  stat;
        logic [31:0] icnt;
    } obs_t;

    logic  Clk = 1'b0;
    logic  Reset_n = 1'b0;
    obs_t  exp_q[$];
    obs_t  mon_act;
    obs_t  mon_exp;
    logic  halted_seen = 1'b0;
    logic [5:0] mon_ev;
    int    n_cmp = 0;
    int    n_fail = 0;
    string cur_test = "init";

    logic [63:0] m_pc;
    logic [2:0]  m_cc;
    logic [3:0]  m_stat;
    logic [31:0] m_icnt;

    always #5 Clk = ~Clk;

    y86_seq_controller_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bus ();

    y86_seq_controller #(
        .PC_WIDTH(PCW), .IMEM_LIMIT(256), .RESET_PC(64'd0), .CNT_WIDTH(CW), .MEM_TIMEOUT(MEMTO)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
    );

    function automatic void push_exp(input logic [5:0] s);
        obs_t e;
        e.strobes = s; e.pc = m_pc; e.cc = m_cc; e.stat = m_stat; e.icnt = m_icnt;
        exp_q.push_back(e);
    endfunction

    function automatic logic [159:0] snap();
        return 160'({bus.PC, bus.ConditionCodes, bus.Status, bus.Fetch_En, bus.Decode_En,
                     bus.Execute_En, bus.Memory_En, bus.Writeback_En, bus.Running, bus.Halted,
                     bus.Cycle_Count, bus.Instr_Count});
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_drain();
        #2;
        check({cur_test, " pending"}, 160'(exp_q.size()), 160'(0));
    endtask

    // Monitor: one scoreboard entry per stage strobe or per entry into the halted state.
    always begin
        @(negedge Clk);
        #1;
        mon_ev = {bus.Halted && !halted_seen, bus.Writeback_En, bus.Memory_En,
                  bus.Execute_En, bus.Decode_En, bus.Fetch_En};
        halted_seen = bus.Halted;
        if (mon_ev != 6'b000000) begin
            mon_act.strobes = mon_ev; mon_act.pc = bus.PC; mon_act.cc = bus.ConditionCodes;
            mon_act.stat = bus.Status; mon_act.icnt = bus.Instr_Count;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s unexpected event: got strobes=%b pc=%0d stat=%0d", cur_test,
                         mon_act.strobes, mon_act.pc, mon_act.stat);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL %s event: got strobes=%b pc=%0d cc=%b stat=%0d icnt=%0d, expected strobes=%b pc=%0d cc=%b stat=%0d icnt=%0d",
                             cur_test, mon_act.strobes, mon_act.pc, mon_act.cc, mon_act.stat, mon_act.icnt,
                             mon_exp.strobes, mon_exp.pc, mon_exp.cc, mon_exp.stat, mon_exp.icnt);
                end
            end
        end
    end

    // Reset, check reset state, idle two cycles with Start low, then start; returns in FETCH.
    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0; bus.Start = 1'b0; bus.Step = 1'b0; bus.Step_Mode = 1'b0;
        bus.icode = 4'h1; bus.HLT = 1'b0; bus.INS = 1'b0; bus.ADR = 1'b0;
        bus.DataMemError = 1'b0; bus.Mem_Ready = 1'b0; bus.NewPC = 64'd0; bus.ConditionCodes_Out = 3'b000;
        m_pc = 64'd0; m_cc = 3'b000; m_stat = STAT_AOK; m_icnt = 32'd0;
        #1 check({cur_test, " reset"}, snap(), RESET_SNAP);
        @(negedge Clk); Reset_n = 1'b1;
        @(negedge Clk); @(negedge Clk);
        bus.Start = 1'b1;
        @(negedge Clk);
    endtask

    // Called at a negedge inside FETCH; returns at the negedge of the following state.
    task automatic run_instr(input logic [3:0] ic, input logic hlt, input logic ins, input logic adr,
                             input logic [63:0] npc, input logic [2:0] cco, input int mwait,
                             input logic dmerr);
        bus.icode = ic; bus.HLT = hlt; bus.INS = ins; bus.ADR = adr; bus.NewPC = npc;
        bus.ConditionCodes_Out = cco; bus.Mem_Ready = 1'b0; bus.DataMemError = 1'b0;
        push_exp(S_F);
        if (hlt) m_stat = STAT_HLT;
        else if (ins) m_stat = STAT_INS;
        else if (adr || (m_pc >= 64'd256)) m_stat = STAT_ADR;
        if (m_stat != STAT_AOK) begin
            push_exp(S_STOP);
            @(negedge Clk);
            return;
        end
        @(negedge Clk); push_exp(S_D);
        @(negedge Clk); push_exp(S_E);
        if (ic == ICODE_OPQ) m_cc = cco;
        for (int k = 1; k <= MEMTO; k++) begin
            @(negedge Clk); push_exp(S_M);
            if (dmerr) begin
                bus.DataMemError = 1'b1; bus.Mem_Ready = 1'b1; m_stat = STAT_ADR; push_exp(S_STOP);
                @(negedge Clk);
                bus.DataMemError = 1'b0; bus.Mem_Ready = 1'b0;
                return;
            end
            if (k > mwait) begin
                bus.Mem_Ready = 1'b1;
                break;
            end
            if (k == MEMTO) begin
                m_stat = STAT_ADR; push_exp(S_STOP);
                @(negedge Clk);
                return;
            end
        end
        @(negedge Clk); bus.Mem_Ready = 1'b0; push_exp(S_W);
        m_pc = npc; m_icnt = m_icnt + 32'd1;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        // 1: irmovq then halt
        cur_test = "t1_irmovq_halt";
        do_reset();
        run_instr(ICODE_IRMOVQ, 1'b0, 1'b0, 1'b0, 64'd10, 3'b000, 0, 1'b0);
        run_instr(ICODE_HALT, 1'b1, 1'b0, 1'b0, 64'd11, 3'b000, 0, 1'b0);
        check("t1_cycles", 160'(bus.Cycle_Count), 160'(32'd7));
        repeat (3) @(negedge Clk);
        check("t1_frozen", 160'({bus.PC, bus.Status, bus.Running, bus.Cycle_Count}),
              160'({64'd10, 4'd4, 1'b0, 32'd7}));
        check_drain();

        // 2: fetch fault priorities
        cur_test = "t2_ins";
        do_reset();
        run_instr(4'hF, 1'b0, 1'b1, 1'b0, 64'd2, 3'b000, 0, 1'b0);
        check_drain();
        cur_test = "t2_hlt_over_all";
        do_reset();
        run_instr(ICODE_HALT, 1'b1, 1'b1, 1'b1, 64'd2, 3'b000, 0, 1'b0);
        check_drain();
        cur_test = "t2_ins_over_adr";
        do_reset();
        run_instr(4'hF, 1'b0, 1'b1, 1'b1, 64'd2, 3'b000, 0, 1'b0);
        check_drain();
        cur_test = "t2_adr_flag";
        do_reset();
        run_instr(ICODE_NOP, 1'b0, 1'b0, 1'b1, 64'd2, 3'b000, 0, 1'b0);
        check_drain();

        // 3: condition codes only from OPq
        cur_test = "t3_cc";
        do_reset();
        run_instr(ICODE_OPQ, 1'b0, 1'b0, 1'b0, 64'd2, 3'b100, 0, 1'b0);
        run_instr(ICODE_IRMOVQ, 1'b0, 1'b0, 1'b0, 64'd12, 3'b010, 0, 1'b0);
        run_instr(ICODE_HALT, 1'b1, 1'b0, 1'b0, 64'd13, 3'b001, 0, 1'b0);
        check_drain();

        // 4: memory wait, wait just under timeout, timeout
        cur_test = "t4_mem_wait";
        do_reset();
        run_instr(ICODE_MRMOVQ, 1'b0, 1'b0, 1'b0, 64'd10, 3'b111, 3, 1'b0);
        run_instr(ICODE_MRMOVQ, 1'b0, 1'b0, 1'b0, 64'd20, 3'b111, MEMTO - 1, 1'b0);
        run_instr(ICODE_MRMOVQ, 1'b0, 1'b0, 1'b0, 64'd30, 3'b111, 99, 1'b0);
        check_drain();
        cur_test = "t4_err_beats_ready";
        do_reset();
        run_instr(ICODE_MRMOVQ, 1'b0, 1'b0, 1'b0, 64'd10, 3'b000, 0, 1'b1);
        check_drain();

        // 5: single step
        cur_test = "t5_step";
        do_reset();
        bus.Step_Mode = 1'b1;
        run_instr(ICODE_IRMOVQ, 1'b0, 1'b0, 1'b0, 64'd10, 3'b000, 0, 1'b0);
        repeat (3) @(negedge Clk);
        check("t5_pause1", 160'({bus.Running, bus.PC, bus.Instr_Count}), 160'({1'b0, 64'd10, 32'd1}));
        bus.Step = 1'b1;
        @(negedge Clk);
        bus.Step = 1'b0;
        run_instr(ICODE_IRMOVQ, 1'b0, 1'b0, 1'b0, 64'd20, 3'b000, 0, 1'b0);
        repeat (2) @(negedge Clk);
        check("t5_pause2", 160'({bus.Running, bus.PC, bus.Instr_Count}), 160'({1'b0, 64'd20, 32'd2}));
        bus.Step_Mode = 1'b0;
        @(negedge Clk);
        run_instr(ICODE_HALT, 1'b1, 1'b0, 1'b0, 64'd21, 3'b000, 0, 1'b0);
        check_drain();

        // 6: asynchronous reset in MEMORY, then PC range boundary
        cur_test = "t6_async_reset";
        do_reset();
        bus.icode = ICODE_MRMOVQ; bus.NewPC = 64'd10; bus.Mem_Ready = 1'b0;
        push_exp(S_F); @(negedge Clk);
        push_exp(S_D); @(negedge Clk);
        push_exp(S_E); @(negedge Clk);
        push_exp(S_M);
        #2 Reset_n = 1'b0;
        #1 check("t6_async_reset", snap(), RESET_SNAP);
        repeat (2) @(negedge Clk);
        check_drain();
        cur_test = "t6_pc_limit";
        do_reset();
        run_instr(ICODE_IRMOVQ, 1'b0, 1'b0, 1'b0, 64'd255, 3'b000, 0, 1'b0);
        run_instr(ICODE_NOP, 1'b0, 1'b0, 1'b0, 64'd256, 3'b000, 0, 1'b0);
        run_instr(ICODE_NOP, 1'b0, 1'b0, 1'b0, 64'd257, 3'b000, 0, 1'b0);
        check("t6_limit_state", 160'({bus.PC, bus.Status, bus.Halted}), 160'({64'd256, 4'd2, 1'b1}));
        check_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
